trng_word_reader: RTL

- Consumer for the trng byte stream: decimates the free-running `rnd_byte` bus, health-tests each sample, and packs samples into WORD_BYTES-wide words.
- Words are buffered in a small FIFO and delivered downstream over a valid/ready interface.
- Sits between the trng core and the system bus or key-generation logic. Raises a sticky fault on a stuck source.

---
 rtl/trng_word_reader_if.sv | 24 ++
 rtl/trng_word_reader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/trng_word_reader_if.sv
`default_nettype none
// =====================================================================
// trng_word_reader_if : valid/ready word delivery bus      Rev 1.0
// =====================================================================
interface trng_word_reader_if #(
    parameter int WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/trng_word_reader.sv
`default_nettype none
// =====================================================================
// trng_word_reader : decimates, health-tests and packs trng bytes into
//                    FIFO-buffered words.                  Rev 1.0
// =====================================================================
module trng_word_reader #(
    parameter int WORD_BYTES     = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int SAMPLE_DIV     = 8,
    parameter int WARMUP_SAMPLES = 2,
    parameter int REP_LIMIT      = 4
) (
    input  wire logic                       clk,
    input  wire logic                       n_reset,
    input  wire logic                       enable,
    input  wire logic [7:0]                 rnd_byte,
    input  wire logic                       fault_clr,
    trng_word_reader_if.master              out_if,
    output logic                            fault,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [7:0]                      dropped_cnt
);
    localparam int c_DATA_W = 8 * WORD_BYTES;
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W  = c_AW + 1;
    localparam int c_TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int c_WARM_W = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
    localparam int c_REP_W  = $clog2(REP_LIMIT + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SAMPLE_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(WORD_BYTES - 1);
    localparam logic [c_WARM_W-1:0] c_WARM_LAST =
        c_WARM_W'((WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0);
    localparam logic [c_REP_W-1:0]  c_REP_LIMIT = c_REP_W'(REP_LIMIT);
    localparam logic [c_LVL_W-1:0]  c_DEPTH     = c_LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_COLLECT = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    // With no warmup configured the run starts directly in COLLECT.
    localparam state_t c_RUN_ENTRY = (WARMUP_SAMPLES > 0) ? ST_WARMUP : ST_COLLECT;

    state_t                r_state;
    logic [c_TICK_W-1:0]   r_tick;
    logic [c_WARM_W-1:0]   r_warm;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_DATA_W-1:0]   r_word;
    logic [7:0]            r_prev;
    logic                  r_prev_valid;
    logic [c_REP_W-1:0]    r_rep;

    logic [c_DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;
    logic [7:0]            r_dropped;

    logic                  w_running;
    logic                  w_sample;
    logic [c_REP_W-1:0]    w_rep_next;
    logic                  w_rep_fire;
    logic                  w_word_done;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [c_DATA_W-1:0]   w_next_word;

    assign w_running   = (r_state == ST_WARMUP) || (r_state == ST_COLLECT);
    assign w_sample    = w_running && enable && (r_tick == c_TICK_LAST);
    assign w_rep_next  = (r_prev_valid && (rnd_byte == r_prev)) ? r_rep + 1'b1
                                                                : c_REP_W'(1);
    assign w_rep_fire  = w_sample && (w_rep_next == c_REP_LIMIT);
    assign w_word_done = w_sample && !w_rep_fire && (r_state == ST_COLLECT)
                         && (r_idx == c_IDX_LAST);
    assign w_pop       = out_if.out_valid && out_if.out_ready;
    assign w_push      = w_word_done && ((r_level < c_DEPTH) || w_pop);
    assign w_drop      = w_word_done && !w_push;

    always_comb begin
        w_next_word = r_word;
        w_next_word[8*r_idx +: 8] = rnd_byte;
    end

    // Sequencing, decimation, repetition history and word packing.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state      <= ST_IDLE;
            r_tick       <= '0;
            r_warm       <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_rep        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= c_RUN_ENTRY;
                        r_tick  <= '0;
                        r_warm  <= '0;
                    end
                end
                ST_WARMUP, ST_COLLECT: begin
                    // Stopping and faulting both discard all in-flight sample state;
                    // clearing the history on fault lets a stuck source re-trip.
                    if (!enable || w_rep_fire) begin
                        r_state      <= enable ? ST_FAULT : ST_IDLE;
                        r_tick       <= '0;
                        r_warm       <= '0;
                        r_idx        <= '0;
                        r_word       <= '0;
                        r_prev_valid <= 1'b0;
                        r_rep        <= '0;
                    end else begin
                        r_tick <= (r_tick == c_TICK_LAST) ? '0 : r_tick + 1'b1;
                        if (w_sample) begin
                            r_prev       <= rnd_byte;
                            r_prev_valid <= 1'b1;
                            r_rep        <= w_rep_next;
                            if (r_state == ST_WARMUP) begin
                                if (r_warm == c_WARM_LAST) begin
                                    r_state <= ST_COLLECT;
                                    r_warm  <= '0;
                                end else begin
                                    r_warm <= r_warm + 1'b1;
                                end
                            end else if (r_idx == c_IDX_LAST) begin
                                r_idx  <= '0;
                                r_word <= '0;
                            end else begin
                                r_idx  <= r_idx + 1'b1;
                                r_word <= w_next_word;
                            end
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        r_state <= enable ? c_RUN_ENTRY : ST_IDLE;
                        r_tick  <= '0;
                        r_warm  <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_next_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_dropped <= '0;
        end else if (w_rep_fire) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_dropped != 8'hFF)) begin
                r_dropped <= r_dropped + 1'b1;
            end
        end
    end

    assign out_if.out_valid = (r_level != '0);
    assign out_if.out_data  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign fault            = (r_state == ST_FAULT);
    assign fifo_level       = r_level;
    assign dropped_cnt      = r_dropped;

endmodule
`default_nettype wire
